// File: rtl/jtkunio_romarb_pkg.sv
// Shared types and constants for the Kunio video ROM arbiter.
package jtkunio_romarb_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SDRAM_W = 22;
  localparam int unsigned CHAR_W  = 14;
  localparam int unsigned SCR_W   = 17;
  localparam int unsigned OBJ_W   = 18;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_WAIT_RDY = 2'd2
  } state_t;

  localparam logic [1:0] CH_CHAR = 2'd0;
  localparam logic [1:0] CH_SCR  = 2'd1;
  localparam logic [1:0] CH_OBJ  = 2'd2;

endpackage

// File: rtl/jtkunio_romarb_slot.sv
// One-word cache slot for a single ROM client: valid bit, tag and data.
module jtkunio_romarb_slot
  import jtkunio_romarb_pkg::*;
#(
  parameter int unsigned AW = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic [AW-1:0]     addr,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_tag,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] data,
  output logic              ok_c,
  output logic              miss_c
);

  logic          valid;
  logic [AW-1:0] tag;
  logic          match_c;

  // Slot storage, refilled when the arbiter completes a fetch for this client
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else if (wr_en) begin
      valid <= 1'b1;
      tag   <= wr_tag;
      data  <= wr_data;
    end
  end

  // Hit/miss follow addr combinationally so ok drops the cycle addr moves
  always_comb begin
    match_c = valid && (tag == addr);
    ok_c    = cs && match_c;
    miss_c  = cs && !match_c;
  end

endmodule

// File: rtl/jtkunio_romarb.sv
// Round-robin arbiter sharing one SDRAM read port among char/scroll/object ROM fetchers.
module jtkunio_romarb
  import jtkunio_romarb_pkg::*;
#(
  parameter logic [21:0] CHAR_OFFSET = 22'h00000,
  parameter logic [21:0] SCR_OFFSET  = 22'h04000,
  parameter logic [21:0] OBJ_OFFSET  = 22'h24000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               char_cs,
  input  logic [CHAR_W-1:0]  char_addr,
  output logic [DATA_W-1:0]  char_data,
  output logic               char_ok,
  input  logic               scr_cs,
  input  logic [SCR_W-1:0]   scr_addr,
  output logic [DATA_W-1:0]  scr_data,
  output logic               scr_ok,
  input  logic               obj_cs,
  input  logic [OBJ_W-1:0]   obj_addr,
  output logic [DATA_W-1:0]  obj_data,
  output logic               obj_ok,
  output logic               sdram_req,
  output logic [SDRAM_W-1:0] sdram_addr,
  input  logic               sdram_ack,
  input  logic               data_rdy,
  input  logic [DATA_W-1:0]  sdram_din
);

  state_t               state, state_nxt;
  logic [1:0]           sel, sel_nxt, last, last_nxt;
  logic [OBJ_W-1:0]     lat_addr, lat_addr_nxt;
  logic                 req_nxt;
  logic [SDRAM_W-1:0]   addr_nxt;
  logic [2:0]           miss_c, fill_c;
  logic [1:0]           pick_c;
  logic [OBJ_W-1:0]     pick_addr_c;
  logic [SDRAM_W-1:0]   pick_sdram_c;

  jtkunio_romarb_slot #(.AW(CHAR_W)) u_char (
    .clk(clk), .rst(rst), .cs(char_cs), .addr(char_addr),
    .wr_en(fill_c[0]), .wr_tag(CHAR_W'(lat_addr)), .wr_data(sdram_din),
    .data(char_data), .ok_c(char_ok), .miss_c(miss_c[0])
  );

  jtkunio_romarb_slot #(.AW(SCR_W)) u_scr (
    .clk(clk), .rst(rst), .cs(scr_cs), .addr(scr_addr),
    .wr_en(fill_c[1]), .wr_tag(SCR_W'(lat_addr)), .wr_data(sdram_din),
    .data(scr_data), .ok_c(scr_ok), .miss_c(miss_c[1])
  );

  jtkunio_romarb_slot #(.AW(OBJ_W)) u_obj (
    .clk(clk), .rst(rst), .cs(obj_cs), .addr(obj_addr),
    .wr_en(fill_c[2]), .wr_tag(lat_addr), .wr_data(sdram_din),
    .data(obj_data), .ok_c(obj_ok), .miss_c(miss_c[2])
  );

  // Round-robin pick: first missing client after the last one served
  always_comb begin
    pick_c = CH_CHAR;
    case (last)
      CH_CHAR: pick_c = miss_c[1] ? CH_SCR  : (miss_c[2] ? CH_OBJ  : CH_CHAR);
      CH_SCR:  pick_c = miss_c[2] ? CH_OBJ  : (miss_c[0] ? CH_CHAR : CH_SCR);
      default: pick_c = miss_c[0] ? CH_CHAR : (miss_c[1] ? CH_SCR  : CH_OBJ);
    endcase
  end

  // Address and region offset of the picked client; the sum wraps at 22 bits
  always_comb begin
    pick_addr_c  = OBJ_W'(char_addr);
    pick_sdram_c = SDRAM_W'(char_addr) + CHAR_OFFSET;
    case (pick_c)
      CH_SCR: begin
        pick_addr_c  = OBJ_W'(scr_addr);
        pick_sdram_c = SDRAM_W'(scr_addr) + SCR_OFFSET;
      end
      CH_OBJ: begin
        pick_addr_c  = obj_addr;
        pick_sdram_c = SDRAM_W'(obj_addr) + OBJ_OFFSET;
      end
      default: ;
    endcase
  end

  // State and registered request/bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      sel        <= CH_CHAR;
      last       <= CH_OBJ;
      lat_addr   <= '0;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
    end else begin
      state      <= state_nxt;
      sel        <= sel_nxt;
      last       <= last_nxt;
      lat_addr   <= lat_addr_nxt;
      sdram_req  <= req_nxt;
      sdram_addr <= addr_nxt;
    end
  end

  // Next-state logic; an ack and rdy in the same cycle complete the fetch at once
  always_comb begin
    state_nxt    = state;
    sel_nxt      = sel;
    last_nxt     = last;
    lat_addr_nxt = lat_addr;
    req_nxt      = sdram_req;
    addr_nxt     = sdram_addr;
    fill_c       = 3'b000;
    case (state)
      ST_IDLE: begin
        if (|miss_c) begin
          sel_nxt      = pick_c;
          lat_addr_nxt = pick_addr_c;
          addr_nxt     = pick_sdram_c;
          req_nxt      = 1'b1;
          state_nxt    = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (sdram_ack) begin
          req_nxt = 1'b0;
          if (data_rdy) begin
            fill_c    = 3'b001 << sel;
            last_nxt  = sel;
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_WAIT_RDY;
          end
        end
      end
      ST_WAIT_RDY: begin
        if (data_rdy) begin
          fill_c    = 3'b001 << sel;
          last_nxt  = sel;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_jtkunio_romarb.sv
// Directed bench for jtkunio_romarb with a hand-driven SDRAM controller.
module tb_jtkunio_romarb;

  logic        clk = 1'b0;
  logic        rst;
  logic        char_cs, scr_cs, obj_cs;
  logic [13:0] char_addr;
  logic [16:0] scr_addr;
  logic [17:0] obj_addr;
  logic [31:0] char_data, scr_data, obj_data;
  logic        char_ok, scr_ok, obj_ok;
  logic        sdram_req;
  logic [21:0] sdram_addr;
  logic        sdram_ack, data_rdy;
  logic [31:0] sdram_din;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  jtkunio_romarb #(.OBJ_OFFSET(22'h3C0001)) dut (
    .clk(clk), .rst(rst),
    .char_cs(char_cs), .char_addr(char_addr), .char_data(char_data), .char_ok(char_ok),
    .scr_cs(scr_cs), .scr_addr(scr_addr), .scr_data(scr_data), .scr_ok(scr_ok),
    .obj_cs(obj_cs), .obj_addr(obj_addr), .obj_data(obj_data), .obj_ok(obj_ok),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr),
    .sdram_ack(sdram_ack), .data_rdy(data_rdy), .sdram_din(sdram_din)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    char_cs = 1'b0; scr_cs = 1'b0; obj_cs = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Wait (bounded) for a request, then check its address
  task automatic wait_req(input string tag, input logic [21:0] exp);
    int n = 0;
    #1;
    while (!sdram_req && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    check({tag, "_req"}, 32'(sdram_req), 32'd1);
    check({tag, "_addr"}, 32'(sdram_addr), 32'(exp));
  endtask

  // Ack, then deliver data the following cycle
  task automatic complete(input string tag, input logic [31:0] d);
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0;
    #1 check({tag, "_req_drop"}, 32'(sdram_req), 32'd0);
    data_rdy = 1'b1; sdram_din = d;
    @(negedge clk);
    data_rdy = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    char_cs = 1'b0; scr_cs = 1'b0; obj_cs = 1'b0;
    char_addr = '0; scr_addr = '0; obj_addr = '0;
    sdram_ack = 1'b0; data_rdy = 1'b0; sdram_din = '0;
    @(negedge clk); #1;
    check("rst_req", 32'(sdram_req), 32'd0);
    check("rst_addr", 32'(sdram_addr), 32'd0);
    check("rst_oks", 32'({char_ok, scr_ok, obj_ok}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single fetch after reset
    char_cs = 1'b1; char_addr = 14'h0010;
    @(negedge clk);
    check("single_req_latency", 32'(sdram_req), 32'd1);
    wait_req("single", 22'h000010);
    complete("single", 32'hDEADBEEF);
    check("single_ok", 32'(char_ok), 32'd1);
    check("single_data", char_data, 32'hDEADBEEF);

    // Cache hit: no new request while the address holds
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("hit_ok", 32'(char_ok), 32'd1);
      check("hit_noreq", 32'(sdram_req), 32'd0);
    end
    char_addr = 14'h0011;
    #1 check("hit_change_ok", 32'(char_ok), 32'd0);
    wait_req("hit_next", 22'h000011);
    complete("hit_next", 32'h11112222);
    check("hit_next_data", char_data, 32'h11112222);
    check("hit_next_ok", 32'(char_ok), 32'd1);

    // Offset with 22-bit wrap
    do_reset();
    obj_cs = 1'b1; obj_addr = 18'h3FFFF;
    wait_req("wrap", 22'h000000);
    complete("wrap", 32'h0BADF00D);
    check("wrap_ok", 32'(obj_ok), 32'd1);
    check("wrap_data", obj_data, 32'h0BADF00D);

    // Round-robin from reset: char, scr, obj
    do_reset();
    char_cs = 1'b1; char_addr = 14'h0030;
    scr_cs  = 1'b1; scr_addr  = 17'h00200;
    obj_cs  = 1'b1; obj_addr  = 18'h00005;
    wait_req("rr_char", 22'h000030);
    complete("rr_char", 32'hC0000001);
    wait_req("rr_scr", 22'h004200);
    complete("rr_scr", 32'h50000002);
    wait_req("rr_obj", 22'h3C0006);
    complete("rr_obj", 32'h0B000003);
    check("rr_all_ok", 32'({char_ok, scr_ok, obj_ok}), 32'h7);
    check("rr_scr_data", scr_data, 32'h50000002);

    // With last = char, scr wins over char
    do_reset();
    char_cs = 1'b1; char_addr = 14'h0040;
    wait_req("rr2_char", 22'h000040);
    complete("rr2_char", 32'hAAAA0040);
    char_addr = 14'h0041;
    scr_cs = 1'b1; scr_addr = 17'h00300;
    wait_req("rr2_scr_first", 22'h004300);
    complete("rr2_scr_first", 32'hBBBB0300);
    wait_req("rr2_char_second", 22'h000041);
    complete("rr2_char_second", 32'hAAAA0041);
    check("rr2_char_data", char_data, 32'hAAAA0041);

    // Address change between ack and data_rdy
    scr_addr = 17'h00100;
    wait_req("mid", 22'h004100);
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0;
    scr_addr = 17'h00101;
    data_rdy = 1'b1; sdram_din = 32'h12345678;
    @(negedge clk);
    data_rdy = 1'b0;
    #1 check("mid_ok_low", 32'(scr_ok), 32'd0);
    check("mid_data", scr_data, 32'h12345678);
    scr_addr = 17'h00100;
    #1 check("mid_old_tag", 32'(scr_ok), 32'd1);
    scr_addr = 17'h00101;
    wait_req("mid_refetch", 22'h004101);
    complete("mid_refetch", 32'h87654321);
    check("mid_refetch_ok", 32'(scr_ok), 32'd1);

    // Reset while in WAIT_ACK
    char_addr = 14'h0020;
    wait_req("rstmid", 22'h000020);
    rst = 1'b1;
    #1 check("rstmid_req", 32'(sdram_req), 32'd0);
    check("rstmid_addr", 32'(sdram_addr), 32'd0);
    check("rstmid_oks", 32'({char_ok, scr_ok, obj_ok}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    scr_cs = 1'b0;

    // Simultaneous ack and rdy
    wait_req("both", 22'h000020);
    sdram_ack = 1'b1; data_rdy = 1'b1; sdram_din = 32'hCAFEF00D;
    @(negedge clk);
    sdram_ack = 1'b0; data_rdy = 1'b0;
    #1 check("both_ok", 32'(char_ok), 32'd1);
    check("both_data", char_data, 32'hCAFEF00D);
    check("both_req", 32'(sdram_req), 32'd0);
    char_addr = 14'h0021;
    @(negedge clk); #1;
    check("both_idle_req", 32'(sdram_req), 32'd1);
    check("both_idle_addr", 32'(sdram_addr), 32'h000021);
    complete("tail", 32'h00000021);
    check("tail_ok", 32'(char_ok), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
